// File: rtl/frame_seq_pkg.sv
// Shared types and phase-window decode for the frame sequencer.
package frame_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    TRST = 3'd1,
    DQ   = 3'd2,
    SR   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Maps a phase value onto its window; zero-length windows are never returned.
  function automatic state_t phase_state(input int unsigned p,
                                         input int unsigned trst_len,
                                         input int unsigned dq_len,
                                         input int unsigned sr_len);
    if (p < trst_len) return TRST;
    if (p < trst_len + dq_len) return DQ;
    if (p < trst_len + dq_len + sr_len) return SR;
    return GAP;
  endfunction

endpackage

// File: rtl/frame_seq_fsm_phase_counter.sv
// Mod-PERIOD phase counter with enable and clear; exposes its next value and a combinational wrap flag.
module frame_seq_fsm_phase_counter #(
  parameter  int unsigned PERIOD = 40,
  localparam int unsigned CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] next_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign wrap_o  = en_i && (count_q == CNT_W'(PERIOD - 1));
  assign count_o = count_q;
  assign next_o  = count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/frame_seq_fsm.sv
// Frame sequencer: drives trst/dq/sr windows and a divided test clock over a
// programmable number of frames, with start/stop/done handshake.
module frame_seq_fsm
  import frame_seq_pkg::*;
#(
  parameter  int unsigned PERIOD   = 40,
  parameter  int unsigned TRST_LEN = 2,
  parameter  int unsigned DQ_LEN   = 16,
  parameter  int unsigned SR_LEN   = 16,
  parameter  int unsigned TCLK_DIV = 1,
  parameter  int unsigned FRAME_W  = 8,
  localparam int unsigned CNT_W    = $clog2(PERIOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [FRAME_W-1:0] i_num_frames,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_tclk,
  output logic               o_trst,
  output logic               o_dq_en,
  output logic               o_sr_en,
  output logic [STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]   o_phase
);

  if (PERIOD < 4 || TRST_LEN + DQ_LEN + SR_LEN > PERIOD ||
      TCLK_DIV < 1 || TCLK_DIV > CNT_W) begin : g_bad_params
    $fatal(1, "frame_seq_fsm: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0] num_frames_q, num_frames_d;
  logic               stop_pending_q, stop_pending_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tclk_q, tclk_d;
  logic               trst_q, trst_d;
  logic               dq_q, dq_d;
  logic               sr_q, sr_d;

  logic [CNT_W-1:0]   phase, phase_nxt;
  logic               wrap;
  logic               active;
  logic [FRAME_W-1:0] frame_inc;
  logic               last_frame;

  assign active = (state_q != IDLE);

  frame_seq_fsm_phase_counter #(.PERIOD(PERIOD)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en_i    (active),
    .clr_i   (!active),
    .count_o (phase),
    .next_o  (phase_nxt),
    .wrap_o  (wrap)
  );

  assign frame_inc  = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + FRAME_W'(1);
  assign last_frame = stop_pending_q || i_stop ||
                      ((num_frames_q != '0) && (frame_inc == num_frames_q));

  // Next state and registered-output values; outputs are derived from state_d
  // so every window flag changes on the same edge as o_state.
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    num_frames_d   = num_frames_q;
    stop_pending_d = stop_pending_q;
    done_d         = 1'b0;

    if (!active) begin
      if (i_start) begin
        state_d        = phase_state(32'(phase_nxt), TRST_LEN, DQ_LEN, SR_LEN);
        num_frames_d   = i_num_frames;
        frame_cnt_d    = '0;
        stop_pending_d = 1'b0;
      end
    end else begin
      stop_pending_d = stop_pending_q || i_stop;
      if (wrap) frame_cnt_d = frame_inc;
      if (wrap && last_frame) begin
        state_d        = IDLE;
        done_d         = 1'b1;
        stop_pending_d = 1'b0;
      end else begin
        state_d = phase_state(32'(phase_nxt), TRST_LEN, DQ_LEN, SR_LEN);
      end
    end

    busy_d = (state_d != IDLE);
    tclk_d = phase_nxt[TCLK_DIV-1] && busy_d;
    trst_d = (state_d == TRST);
    dq_d   = (state_d == DQ);
    sr_d   = (state_d == SR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      frame_cnt_q    <= '0;
      num_frames_q   <= '0;
      stop_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tclk_q         <= 1'b0;
      trst_q         <= 1'b0;
      dq_q           <= 1'b0;
      sr_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      num_frames_q   <= num_frames_d;
      stop_pending_q <= stop_pending_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      tclk_q         <= tclk_d;
      trst_q         <= trst_d;
      dq_q           <= dq_d;
      sr_q           <= sr_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_tclk  = tclk_q;
  assign o_trst  = trst_q;
  assign o_dq_en = dq_q;
  assign o_sr_en = sr_q;
  assign o_state = state_q;
  assign o_phase = phase;

endmodule

// File: tb/tb_frame_seq_fsm.sv
// Scoreboard bench: a frame-level reference model predicts every output cycle
// for a default-parameter instance and a short-period (PERIOD=8, TCLK_DIV=2) instance.
module tb_frame_seq_fsm;

  typedef struct {
    bit run;
    int p;
    int frames;
    int nf;
    bit stop_p;
  } mdl_t;

  typedef struct {
    bit busy, done, tclk, trst, dq, sr;
    int st;
    int ph;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_stop;
  logic [7:0] num_frames;

  logic       busy_a, done_a, tclk_a, trst_a, dq_a, sr_a;
  logic [2:0] state_a;
  logic [5:0] phase_a;
  logic       busy_b, done_b, tclk_b, trst_b, dq_b, sr_b;
  logic [2:0] state_b;
  logic [2:0] phase_b;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t q_a[$];
  vec_t q_b[$];
  mdl_t m_a = '{0, 0, 0, 0, 0};
  mdl_t m_b = '{0, 0, 0, 0, 0};

  frame_seq_fsm u_dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_num_frames(num_frames),
    .o_busy(busy_a), .o_done(done_a), .o_tclk(tclk_a), .o_trst(trst_a),
    .o_dq_en(dq_a), .o_sr_en(sr_a), .o_state(state_a), .o_phase(phase_a)
  );

  frame_seq_fsm #(.PERIOD(8), .TRST_LEN(1), .DQ_LEN(3), .SR_LEN(4), .TCLK_DIV(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_num_frames(num_frames),
    .o_busy(busy_b), .o_done(done_b), .o_tclk(tclk_b), .o_trst(trst_b),
    .o_dq_en(dq_b), .o_sr_en(sr_b), .o_state(state_b), .o_phase(phase_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level behaviour: a running sequencer walks p through one frame,
  // counts frames at p=P-1 and stops there when asked or when the quota is met.
  function automatic mdl_t mdl_next(mdl_t m, bit r, bit s, bit t, int nf, int per);
    mdl_t n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 0};
    end else if (!m.run) begin
      if (s) n = '{1, 0, 0, nf, 0};
    end else if (m.p == per - 1) begin
      n.frames = (m.frames < 255) ? m.frames + 1 : 255;
      n.p      = 0;
      if (m.stop_p || t || (m.nf != 0 && n.frames >= m.nf)) begin
        n.run    = 0;
        n.stop_p = 0;
      end
    end else begin
      n.p      = m.p + 1;
      n.stop_p = m.stop_p | t;
    end
    return n;
  endfunction

  function automatic vec_t mdl_out(mdl_t prev, mdl_t m, bit r, int tl, int dl, int sl, int div);
    vec_t v;
    v.busy = m.run;
    v.done = prev.run && !m.run && !r;
    v.ph   = m.p;
    if (!m.run)                v.st = 0;
    else if (m.p < tl)         v.st = 1;
    else if (m.p < tl + dl)    v.st = 2;
    else if (m.p < tl+dl+sl)   v.st = 3;
    else                       v.st = 4;
    v.trst = (v.st == 1);
    v.dq   = (v.st == 2);
    v.sr   = (v.st == 3);
    v.tclk = m.run && (((m.p >> (div - 1)) & 1) == 1);
    return v;
  endfunction

  function automatic vec_t act_a();
    vec_t v;
    v.busy = busy_a; v.done = done_a; v.tclk = tclk_a;
    v.trst = trst_a; v.dq = dq_a; v.sr = sr_a;
    v.st = int'(state_a); v.ph = int'(phase_a);
    return v;
  endfunction

  function automatic vec_t act_b();
    vec_t v;
    v.busy = busy_b; v.done = done_b; v.tclk = tclk_b;
    v.trst = trst_b; v.dq = dq_b; v.sr = sr_b;
    v.st = int'(state_b); v.ph = int'(phase_b);
    return v;
  endfunction

  task automatic check(input string name, input vec_t a, input vec_t e);
    n_vec++;
    if (a.busy !== e.busy || a.done !== e.done || a.tclk !== e.tclk || a.trst !== e.trst ||
        a.dq !== e.dq || a.sr !== e.sr || a.st != e.st || a.ph != e.ph) begin
      n_bad++;
      $display("FAIL %s t=%0t got busy=%0d done=%0d tclk=%0d trst=%0d dq=%0d sr=%0d st=%0d ph=%0d want busy=%0d done=%0d tclk=%0d trst=%0d dq=%0d sr=%0d st=%0d ph=%0d",
               name, $time, a.busy, a.done, a.tclk, a.trst, a.dq, a.sr, a.st, a.ph,
               e.busy, e.done, e.tclk, e.trst, e.dq, e.sr, e.st, e.ph);
    end
  endtask

  // Monitor: outputs settle after each posedge; compare on the following negedge.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("dut_p40", act_a(), e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("dut_p8", act_b(), e);
      end
    end
  end

  // One cycle of stimulus; expectations are pushed at the sampling edge.
  task automatic drive(input bit r, input bit s, input bit t, input int nf);
    mdl_t n;
    @(negedge clk);
    rst = r; i_start = s; i_stop = t; num_frames = 8'(nf);
    @(posedge clk);
    n = mdl_next(m_a, r, s, t, nf, 40);
    q_a.push_back(mdl_out(m_a, n, r, 2, 16, 16, 1));
    m_a = n;
    n = mdl_next(m_b, r, s, t, nf, 8);
    q_b.push_back(mdl_out(m_b, n, r, 1, 3, 4, 2));
    m_b = n;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; num_frames = '0;
    repeat (3) drive(1, 0, 0, 0);
    idle(2);

    drive(0, 1, 0, 1);   idle(45);                  // single frame
    drive(0, 1, 0, 3);   idle(125);                 // three frames, one done
    drive(0, 1, 0, 0);   idle(49);                  // continuous, stop mid frame 2
    drive(0, 0, 1, 0);   idle(40);
    drive(0, 1, 0, 0);   idle(39);                  // stop on the frame-end cycle
    drive(0, 0, 1, 0);   idle(5);
    drive(0, 1, 0, 0);   idle(20);                  // reset mid-frame
    drive(1, 0, 0, 0);   idle(3);
    drive(0, 1, 0, 2);   idle(5);                   // start while busy is ignored
    drive(0, 1, 0, 1);   idle(90);
    drive(0, 0, 1, 0);   idle(3);                   // stop in IDLE is ignored
    drive(0, 1, 1, 1);   idle(45);                  // start+stop in IDLE: start wins

    for (int i = 0; i < 3000; i++) begin
      bit r, s, t;
      int nf;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 24) == 0);
      t  = ($urandom_range(0, 79) == 0);
      nf = $urandom_range(0, 3);
      drive(r, s, t, nf);
    end

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
